// File: rtl/mini_src_control_unit.sv
// Hardwired T-step control FSM for the Mini SRC CPU: fetch, per-opcode execute, halt.
// Optional single-step boundary wait is compiled in with `define CU_SINGLE_STEP_EN.
module mini_src_control_unit #(
    parameter int MEM_WAIT = 1
) (
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] IR,
    input  logic        CONFF_out,
    input  logic        stop,
`ifdef CU_SINGLE_STEP_EN
    input  logic        step,
`endif
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        PCout_en,
    output logic        IncPC,
    output logic        PC_en,
    output logic        IR_en,
    output logic        Yin,
    output logic        HIout,
    output logic        HIin,
    output logic        LOout,
    output logic        LOin,
    output logic        Cout,
    output logic        Zhighout,
    output logic        Zlowout,
    output logic        Zin,
    output logic        MDRout,
    output logic        MDRin,
    output logic        MARin,
    output logic        memRead,
    output logic        memWrite,
    output logic        inPort_en,
    output logic        outPort_en,
    output logic        inPortOut,
    output logic        CONin,
    output logic [4:0]  opcode,
    output logic        run
);

    typedef enum logic [3:0] {
        S_RESET, S_F0, S_FW, S_F1, S_F2,
        S_E0, S_E1, S_E2, S_EW, S_E3, S_E4,
        S_HALT, S_STEP
    } state_t;

    localparam logic [4:0] OP_LD = 5'd0, OP_LDI = 5'd1, OP_ST = 5'd2, OP_ADD = 5'd3;
    localparam logic [4:0] OP_AND = 5'd5, OP_OR = 5'd6;
    localparam logic [4:0] OP_ADDI = 5'd12, OP_ANDI = 5'd13, OP_ORI = 5'd14;
    localparam logic [4:0] OP_MUL = 5'd15, OP_DIV = 5'd16, OP_NEG = 5'd17, OP_NOT = 5'd18;
    localparam logic [4:0] OP_BR = 5'd19, OP_JR = 5'd20, OP_JAL = 5'd21, OP_IN = 5'd22;
    localparam logic [4:0] OP_OUT = 5'd23, OP_MFHI = 5'd24, OP_MFLO = 5'd25, OP_HALT = 5'd27;
    localparam logic [1:0] WLAST = (MEM_WAIT > 0) ? 2'(MEM_WAIT - 1) : 2'd0;

    state_t     state, nxt, boundary;
    logic [1:0] wcnt;
    logic [4:0] op_q, cur_op;
    logic [2:0] k, last;
    logic       unused_ir;

    assign unused_ir = ^IR[26:0];

    // E0 decodes the IR that was just latched; later steps use the copy taken at E0.
    assign cur_op = (state == S_E0) ? IR[31:27] : op_q;

    function automatic logic [2:0] exec_idx(input state_t s);
        case (s)
            S_E1:    return 3'd1;
            S_E2:    return 3'd2;
            S_E3:    return 3'd3;
            S_E4:    return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    function automatic logic [2:0] last_step(input logic [4:0] op);
        case (op) inside
            OP_LD, OP_ST:            return 3'd4;
            OP_LDI, [OP_ADD:OP_ORI]: return 3'd2;
            OP_MUL, OP_DIV, OP_BR:   return 3'd3;
            OP_NEG, OP_NOT, OP_JAL:  return 3'd1;
            default:                 return 3'd0;
        endcase
    endfunction

    function automatic state_t exec_state(input logic [2:0] idx);
        case (idx)
            3'd1:    return S_E1;
            3'd2:    return S_E2;
            3'd3:    return S_E3;
            3'd4:    return S_E4;
            default: return S_E0;
        endcase
    endfunction

    always_comb begin
`ifdef CU_SINGLE_STEP_EN
        boundary = stop ? S_HALT : S_STEP;
`else
        boundary = stop ? S_HALT : S_F0;
`endif
        k    = exec_idx(state);
        last = last_step(cur_op);
        nxt  = state;
        case (state)
            S_RESET: nxt = S_F0;
            S_F0:    nxt = (MEM_WAIT == 0) ? S_F1 : S_FW;
            S_FW:    nxt = (wcnt == WLAST) ? S_F1 : S_FW;
            S_F1:    nxt = S_F2;
            S_F2:    nxt = S_E0;
            S_EW:    nxt = (wcnt == WLAST) ? S_E3 : S_EW;
            S_E0, S_E1, S_E2, S_E3, S_E4: begin
                if (state == S_E0 && cur_op == OP_HALT)
                    nxt = S_HALT;
                else if (k == last)
                    nxt = boundary;
                else if (cur_op == OP_LD && k == 3'd2 && MEM_WAIT != 0)
                    nxt = S_EW;
                else
                    nxt = exec_state(k + 3'd1);
            end
            S_HALT:  nxt = S_HALT;
`ifdef CU_SINGLE_STEP_EN
            S_STEP:  nxt = stop ? S_HALT : (step ? S_F0 : S_STEP);
`endif
            default: nxt = S_RESET;
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state <= S_RESET;
            wcnt  <= 2'd0;
        end else begin
            state <= nxt;
            wcnt  <= (nxt == state && (state == S_FW || state == S_EW)) ? wcnt + 2'd1 : 2'd0;
        end
        if (state == S_E0)
            op_q <= IR[31:27];
    end

    always_comb begin
        {Gra, Grb, Grc, Rin, Rout, BAout, PCout_en, IncPC, PC_en, IR_en, Yin, HIout, HIin,
         LOout, LOin, Cout, Zhighout, Zlowout, Zin, MDRout, MDRin, MARin, memRead, memWrite,
         outPort_en, inPortOut, CONin} = '0;
        inPort_en = (state != S_RESET);
        run       = (state != S_RESET && state != S_HALT);
        opcode    = (state == S_RESET || state == S_HALT || state == S_STEP) ? 5'd0 : IR[31:27];
        case (state)
            S_F0: begin PCout_en = 1'b1; MARin = 1'b1; IncPC = 1'b1; PC_en = 1'b1; end
            S_FW, S_EW: memRead = 1'b1;
            S_F1: begin memRead = 1'b1; MDRin = 1'b1; end
            S_F2: begin MDRout = 1'b1; IR_en = 1'b1; end
            S_E0: case (cur_op) inside
                OP_LD, OP_LDI, OP_ST: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
                [OP_ADD:OP_ORI]:      begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                OP_MUL, OP_DIV:       begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                OP_NEG, OP_NOT:       begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; end
                OP_BR:   begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
                OP_JR:   begin Gra = 1'b1; Rout = 1'b1; PC_en = 1'b1; end
                OP_JAL:  begin PCout_en = 1'b1; Grb = 1'b1; Rin = 1'b1; end
                OP_IN:   begin inPortOut = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                OP_OUT:  begin Gra = 1'b1; Rout = 1'b1; outPort_en = 1'b1; end
                OP_MFHI: begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                OP_MFLO: begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                default: ;
            endcase
            S_E1: case (cur_op) inside
                OP_LD, OP_LDI, OP_ST: begin Cout = 1'b1; Zin = 1'b1; opcode = OP_ADD; end
                [OP_ADD:5'd11]:       begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; end
                [OP_ADDI:OP_ORI]: begin
                    Cout   = 1'b1;
                    Zin    = 1'b1;
                    opcode = (cur_op == OP_ADDI) ? OP_ADD : ((cur_op == OP_ANDI) ? OP_AND : OP_OR);
                end
                OP_MUL, OP_DIV: begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; end
                OP_NEG, OP_NOT: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                OP_BR:          begin PCout_en = 1'b1; Yin = 1'b1; end
                OP_JAL:         begin Gra = 1'b1; Rout = 1'b1; PC_en = 1'b1; end
                default: ;
            endcase
            S_E2: case (cur_op) inside
                OP_LD, OP_ST:            begin Zlowout = 1'b1; MARin = 1'b1; end
                OP_LDI, [OP_ADD:OP_ORI]: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                OP_MUL, OP_DIV:          begin Zlowout = 1'b1; LOin = 1'b1; end
                OP_BR:                   begin Cout = 1'b1; Zin = 1'b1; opcode = OP_ADD; end
                default: ;
            endcase
            S_E3: case (cur_op) inside
                OP_LD:          begin memRead = 1'b1; MDRin = 1'b1; end
                OP_ST:          begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
                OP_MUL, OP_DIV: begin Zhighout = 1'b1; HIin = 1'b1; end
                OP_BR:          begin Zlowout = 1'b1; PC_en = CONFF_out; end
                default: ;
            endcase
            S_E4: case (cur_op) inside
                OP_LD:   begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                OP_ST:   memWrite = 1'b1;
                default: ;
            endcase
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mini_src_control_unit.sv
// Bench for mini_src_control_unit: instruction-level recipe model driving per-cycle checks.
module tb_mini_src_control_unit;
    localparam int MW = 1;

    localparam logic [28:0] GRA = 29'd1 << 28, GRB = 29'd1 << 27, GRC = 29'd1 << 26;
    localparam logic [28:0] RIN = 29'd1 << 25, ROUT = 29'd1 << 24, BAO = 29'd1 << 23;
    localparam logic [28:0] PCOUT = 29'd1 << 22, INCPC = 29'd1 << 21, PCEN = 29'd1 << 20;
    localparam logic [28:0] IREN = 29'd1 << 19, YIN = 29'd1 << 18, HIO = 29'd1 << 17;
    localparam logic [28:0] HIIN = 29'd1 << 16, LOO = 29'd1 << 15, LOIN = 29'd1 << 14;
    localparam logic [28:0] COUT = 29'd1 << 13, ZHI = 29'd1 << 12, ZLO = 29'd1 << 11;
    localparam logic [28:0] ZIN = 29'd1 << 10, MDROUT = 29'd1 << 9, MDRIN = 29'd1 << 8;
    localparam logic [28:0] MARIN = 29'd1 << 7, MEMRD = 29'd1 << 6, MEMWR = 29'd1 << 5;
    localparam logic [28:0] INP = 29'd1 << 4, OUTP = 29'd1 << 3, INPO = 29'd1 << 2;
    localparam logic [28:0] CONIN = 29'd1 << 1, RUN = 29'd1;

    logic        clock = 1'b0, clear = 1'b1, CONFF_out = 1'b0, stop = 1'b0, step = 1'b1;
    logic [31:0] IR = 32'd0;
    logic Gra, Grb, Grc, Rin, Rout, BAout, PCout_en, IncPC, PC_en, IR_en, Yin, HIout, HIin;
    logic LOout, LOin, Cout, Zhighout, Zlowout, Zin, MDRout, MDRin, MARin, memRead, memWrite;
    logic inPort_en, outPort_en, inPortOut, CONin, run;
    logic [4:0]  opcode;
    logic [28:0] act;

    int checks = 0, failures = 0;
    logic [28:0] qv[$];
    logic [4:0]  qo[$];
    string       qn[$];
    logic [31:0] prev_ir = 32'd0;

    mini_src_control_unit #(.MEM_WAIT(MW)) dut (
        .clock(clock), .clear(clear), .IR(IR), .CONFF_out(CONFF_out), .stop(stop),
`ifdef CU_SINGLE_STEP_EN
        .step(step),
`endif
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
        .PCout_en(PCout_en), .IncPC(IncPC), .PC_en(PC_en), .IR_en(IR_en), .Yin(Yin),
        .HIout(HIout), .HIin(HIin), .LOout(LOout), .LOin(LOin), .Cout(Cout),
        .Zhighout(Zhighout), .Zlowout(Zlowout), .Zin(Zin), .MDRout(MDRout), .MDRin(MDRin),
        .MARin(MARin), .memRead(memRead), .memWrite(memWrite), .inPort_en(inPort_en),
        .outPort_en(outPort_en), .inPortOut(inPortOut), .CONin(CONin), .opcode(opcode), .run(run)
    );

    assign act = {Gra, Grb, Grc, Rin, Rout, BAout, PCout_en, IncPC, PC_en, IR_en, Yin, HIout,
                  HIin, LOout, LOin, Cout, Zhighout, Zlowout, Zin, MDRout, MDRin, MARin,
                  memRead, memWrite, inPort_en, outPort_en, inPortOut, CONin, run};

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input logic [28:0] ev, input logic [4:0] eo, input string nm);
        checks++;
        if (act !== ev || opcode !== eo) begin
            failures++;
            $display("FAIL %s ctrl=%h op=%b expected ctrl=%h op=%b", nm, act, opcode, ev, eo);
        end
    endtask

    task automatic pin(input logic cond, input string nm);
        checks++;
        if (!cond) begin
            failures++;
            $display("FAIL model_%s got=0 expected=1", nm);
        end
    endtask

    task automatic p(input logic [28:0] v, input logic [4:0] o, input string n);
        qv.push_back(v | INP | RUN);
        qo.push_back(o);
        qn.push_back(n);
    endtask

    // Execute-phase recipe for one instruction, written straight from the opcode table.
    task automatic plan(input logic [4:0] op, input logic conff);
        qv.delete(); qo.delete(); qn.delete();
        if (op == 5'd0 || op == 5'd2) begin
            p(GRB | BAO | YIN, op, "E0"); p(COUT | ZIN, 5'd3, "E1"); p(ZLO | MARIN, op, "E2");
            if (op == 5'd0) begin
                repeat (MW) p(MEMRD, op, "EW");
                p(MEMRD | MDRIN, op, "E3"); p(MDROUT | GRA | RIN, op, "E4");
            end else begin
                p(GRA | ROUT | MDRIN, op, "E3"); p(MEMWR, op, "E4");
            end
        end else if (op == 5'd1) begin
            p(GRB | BAO | YIN, op, "E0"); p(COUT | ZIN, 5'd3, "E1"); p(ZLO | GRA | RIN, op, "E2");
        end else if (op >= 5'd3 && op <= 5'd11) begin
            p(GRB | ROUT | YIN, op, "E0"); p(GRC | ROUT | ZIN, op, "E1"); p(ZLO | GRA | RIN, op, "E2");
        end else if (op >= 5'd12 && op <= 5'd14) begin
            p(GRB | ROUT | YIN, op, "E0");
            p(COUT | ZIN, (op == 5'd12) ? 5'd3 : ((op == 5'd13) ? 5'd5 : 5'd6), "E1");
            p(ZLO | GRA | RIN, op, "E2");
        end else if (op == 5'd15 || op == 5'd16) begin
            p(GRA | ROUT | YIN, op, "E0"); p(GRB | ROUT | ZIN, op, "E1");
            p(ZLO | LOIN, op, "E2"); p(ZHI | HIIN, op, "E3");
        end else if (op == 5'd17 || op == 5'd18) begin
            p(GRB | ROUT | ZIN, op, "E0"); p(ZLO | GRA | RIN, op, "E1");
        end else if (op == 5'd19) begin
            p(GRA | ROUT | CONIN, op, "E0"); p(PCOUT | YIN, op, "E1");
            p(COUT | ZIN, 5'd3, "E2"); p(ZLO | (conff ? PCEN : 29'd0), op, "E3");
        end else if (op == 5'd20) p(GRA | ROUT | PCEN, op, "E0");
        else if (op == 5'd21) begin
            p(PCOUT | GRB | RIN, op, "E0"); p(GRA | ROUT | PCEN, op, "E1");
        end
        else if (op == 5'd22) p(INPO | GRA | RIN, op, "E0");
        else if (op == 5'd23) p(GRA | ROUT | OUTP, op, "E0");
        else if (op == 5'd24) p(HIO | GRA | RIN, op, "E0");
        else if (op == 5'd25) p(LOO | GRA | RIN, op, "E0");
        else p(29'd0, op, "E0");
    endtask

    task automatic halt_then_clear();
        repeat (3) begin
            chk(INP, 5'd0, "halt");
            stop = 1'($urandom_range(0, 1));
            tick();
        end
        stop = 1'b0;
        tick();
        chk(INP, 5'd0, "halt_stop_low");
        clear = 1'b1;
        tick();
        chk(29'd0, 5'd0, "reset_from_halt");
        clear = 1'b0;
        tick();
    endtask

    // Runs one instruction starting in F0; leaves the DUT in F0 (or handles halt/reset).
    task automatic run_instr(input logic [31:0] ir, input logic conff, input logic stop_b,
                             input logic abort_e3);
        logic [4:0] fop;
        fop = prev_ir[31:27];
        chk(PCOUT | MARIN | INCPC | PCEN | INP | RUN, fop, "F0");
        stop = 1'($urandom_range(0, 1));
        tick();
        repeat (MW) begin
            chk(MEMRD | INP | RUN, fop, "FW");
            tick();
        end
        chk(MEMRD | MDRIN | INP | RUN, fop, "F1");
        tick();
        chk(MDROUT | IREN | INP | RUN, fop, "F2");
        IR = ir;
        prev_ir = ir;
        CONFF_out = conff;
        tick();
        plan(ir[31:27], conff);
        for (int i = 0; i < qv.size(); i++) begin
            chk(qv[i], qo[i], qn[i]);
            if (abort_e3 && qn[i] == "E3") begin
                clear = 1'b1;
                stop = 1'b0;
                tick();
                chk(29'd0, 5'd0, "reset_mid_instr");
                clear = 1'b0;
                tick();
                return;
            end
            stop = (i == qv.size() - 1) ? stop_b : 1'($urandom_range(0, 1));
            tick();
        end
        if (stop_b || ir[31:27] == 5'd27) halt_then_clear();
        else begin
`ifdef CU_SINGLE_STEP_EN
            chk(INP | RUN, 5'd0, "step_wait");
            stop = 1'b0;
            tick();
`endif
            stop = 1'b0;
        end
    endtask

    initial begin
        logic [31:0] r;
        logic [4:0]  op;
        plan(5'd3, 1'b0);
        pin(qv.size() == 3 && qv[1] == (GRC | ROUT | ZIN | INP | RUN) && qo[1] == 5'b00011, "add_e1");
        pin(qv[2] == (ZLO | GRA | RIN | INP | RUN), "add_e2");
        plan(5'b01100, 1'b0);
        pin(qo[1] == 5'b00011 && (qv[1] & COUT) != 0, "addi_e1");
        plan(5'b01111, 1'b0);
        pin((qv[2] & LOIN) != 0 && (qv[3] & HIIN) != 0, "mul_lo_hi");
        plan(5'b10011, 1'b1);
        pin((qv[3] & PCEN) != 0, "br_taken");
        plan(5'b10011, 1'b0);
        pin((qv[3] & PCEN) == 0, "br_not_taken");

        tick(); tick();
        chk(29'd0, 5'd0, "reset");
        clear = 1'b0;
        tick();

        run_instr(32'h18918000, 1'b0, 1'b0, 1'b0);
        run_instr({5'b01100, 27'h0123456}, 1'b0, 1'b0, 1'b0);
        run_instr({5'b01111, 27'h0ABCDEF}, 1'b0, 1'b0, 1'b0);
        run_instr({5'b10011, 27'h0000010}, 1'b0, 1'b0, 1'b0);
        run_instr({5'b10011, 27'h0000010}, 1'b1, 1'b0, 1'b0);
        run_instr({5'b00000, 27'h0000777}, 1'b0, 1'b0, 1'b1);
        run_instr({5'b00000, 27'h0000777}, 1'b0, 1'b0, 1'b0);
        run_instr({5'b00010, 27'h0000123}, 1'b0, 1'b0, 1'b0);
        run_instr(32'h18918000, 1'b0, 1'b1, 1'b0);
        run_instr({5'b11011, 27'h0}, 1'b0, 1'b0, 1'b0);
        run_instr({5'b11101, 27'h0}, 1'b0, 1'b0, 1'b0);

        for (int n = 0; n < 300; n++) begin
            r  = $urandom;
            op = 5'($urandom_range(0, 31));
            run_instr({op, r[26:0]}, 1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0),
                      (op == 5'd0 && $urandom_range(0, 3) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
